// File: rtl/comp4b_stim_chk.sv
// comp4b_stim_chk: exhaustive stimulus generator and checker for a 4-bit
// magnitude comparator. One sweep walks {a,b} from 0x00 to 0xFF (b fastest),
// waits SETTLE cycles per vector, then samples the comparator's g/e/l.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   start      request one sweep (accepted only when idle or done)
//   a, b       registered comparator operands
//   g, e, l    comparator responses (A>B, A==B, A<B)
//   busy       sweep in progress
//   done       sweep finished; held until the next accepted start
//   pass       valid with done; 1 when no vector mismatched
//   err_cnt    mismatching vectors in the current/last sweep (0..256)
//   fail_seen  at least one mismatch recorded in this sweep
//   fail_vec   {a,b} of the first mismatching vector

module comp4b_stim_chk #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] a,
    output logic [3:0] b,
    input  logic       g,
    input  logic       e,
    input  logic       l,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_cnt,
    output logic       fail_seen,
    output logic [7:0] fail_vec
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Last settle count before moving to CHECK.
    localparam logic [3:0] WCNT_LAST = 4'(SETTLE - 1);

    logic [1:0] state, state_d;
    logic [7:0] idx, idx_d;
    logic [3:0] wcnt, wcnt_d;
    logic       done_d;
    logic       pass_d;
    logic [8:0] err_cnt_d;
    logic       fail_seen_d;
    logic [7:0] fail_vec_d;

    logic [2:0] exp_resp;
    logic       mismatch;
    logic [7:0] idx_nxt;

    // Operands come straight from the registered index, so they are glitch-free
    // and hold 0xF/0xF once the sweep parks in DONE.
    assign a = idx[7:4];
    assign b = idx[3:0];

    assign busy = (state == ST_SETTLE) || (state == ST_CHECK);

    // Any bit difference counts, so non-one-hot responses are caught too.
    assign exp_resp = {(a > b), (a == b), (a < b)};
    assign mismatch = ({g, e, l} != exp_resp);
    assign idx_nxt  = idx + 8'd1;

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        wcnt_d      = wcnt;
        done_d      = done;
        pass_d      = pass;
        err_cnt_d   = err_cnt;
        fail_seen_d = fail_seen;
        fail_vec_d  = fail_vec;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_SETTLE;
                    idx_d       = 8'd0;
                    wcnt_d      = 4'd0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_cnt_d   = 9'd0;
                    fail_seen_d = 1'b0;
                    fail_vec_d  = 8'd0;
                end
            end

            ST_SETTLE: begin
                wcnt_d = wcnt + 4'd1;
                if (wcnt == WCNT_LAST) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (mismatch) begin
                    err_cnt_d = err_cnt + 9'd1;
                    if (!fail_seen) begin
                        fail_seen_d = 1'b1;
                        fail_vec_d  = {a, b};
                    end
                end
                if (idx != 8'hFF) begin
                    idx_d   = idx_nxt;
                    wcnt_d  = 4'd0;
                    state_d = ST_SETTLE;
                end else begin
                    // Verdict includes the mismatch of this final vector.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == 9'd0);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= 8'd0;
            wcnt      <= 4'd0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= 9'd0;
            fail_seen <= 1'b0;
            fail_vec  <= 8'd0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            wcnt      <= wcnt_d;
            done      <= done_d;
            pass      <= pass_d;
            err_cnt   <= err_cnt_d;
            fail_seen <= fail_seen_d;
            fail_vec  <= fail_vec_d;
        end
    end

endmodule
